// File: rtl/rtl_uart_phy.sv
// 8N1 asynchronous serial engine below the ACIA register block: one TX serialiser and one RX
// deserialiser sharing a single elaboration-time baud divisor, fully independent of each other.
module rtl_uart_phy #(
  parameter int SYSCLK_MHZ = 27,
  parameter int BAUD_RATE  = 115200
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       rxd,
  output logic       rx_rdy,
  output logic [7:0] rx_data,
  output logic       rx_frame_err,
  output logic       rx_sample_pulse,
  input  logic       ena_tx,
  input  logic [7:0] tx_data,
  output logic       txd,
  output logic       tx_busy
);

  localparam int DIV  = (SYSCLK_MHZ * 1000000 + BAUD_RATE / 2) / BAUD_RATE;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV + 1);

  generate
    if (DIV < 4) begin : g_div_too_small
      $error("rtl_uart_phy: baud divisor below 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } ph_state_t;

  ph_state_t         tx_state_r, tx_state_s;
  logic [CW-1:0]     tx_cnt_r, tx_cnt_s;
  logic [2:0]        tx_bit_r, tx_bit_s;
  logic [7:0]        tx_shift_r, tx_shift_s;
  logic              txd_r, txd_s;
  logic              tx_busy_r, tx_busy_s;
  logic              tx_end_s;

  // TX next-state: each phase lasts DIV cycles; txd/tx_busy are decoded from the next state
  always_comb begin
    tx_state_s = tx_state_r;
    tx_cnt_s   = tx_cnt_r;
    tx_bit_s   = tx_bit_r;
    tx_shift_s = tx_shift_r;
    tx_end_s   = (tx_cnt_r == CW'(DIV - 1));
    case (tx_state_r)
      ST_IDLE: begin
        if (ena_tx) begin
          tx_shift_s = tx_data;
          tx_cnt_s   = '0;
          tx_bit_s   = 3'd0;
          tx_state_s = ST_START;
        end else begin
          tx_state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (tx_end_s) begin
          tx_cnt_s   = '0;
          tx_state_s = ST_DATA;
        end else begin
          tx_cnt_s = tx_cnt_r + CW'(1);
        end
      end
      ST_DATA: begin
        if (tx_end_s) begin
          tx_cnt_s   = '0;
          tx_shift_s = {1'b0, tx_shift_r[7:1]};
          tx_bit_s   = tx_bit_r + 3'd1;
          if (tx_bit_r == 3'd7) begin
            tx_state_s = ST_STOP;
          end else begin
            tx_state_s = ST_DATA;
          end
        end else begin
          tx_cnt_s = tx_cnt_r + CW'(1);
        end
      end
      ST_STOP: begin
        if (tx_end_s) begin
          tx_cnt_s   = '0;
          tx_state_s = ST_IDLE;
        end else begin
          tx_cnt_s = tx_cnt_r + CW'(1);
        end
      end
      default: begin
        tx_state_s = ST_IDLE;
      end
    endcase
    case (tx_state_s)
      ST_START: txd_s = 1'b0;
      ST_DATA:  txd_s = tx_shift_s[0];
      default:  txd_s = 1'b1;
    endcase
    tx_busy_s = (tx_state_s != ST_IDLE);
  end

  // TX state and registered line outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tx_state_r <= ST_IDLE;
      tx_cnt_r   <= '0;
      tx_bit_r   <= 3'd0;
      tx_shift_r <= 8'h00;
      txd_r      <= 1'b1;
      tx_busy_r  <= 1'b0;
    end else begin
      tx_state_r <= tx_state_s;
      tx_cnt_r   <= tx_cnt_s;
      tx_bit_r   <= tx_bit_s;
      tx_shift_r <= tx_shift_s;
      txd_r      <= txd_s;
      tx_busy_r  <= tx_busy_s;
    end
  end

  logic              rx_meta_r, rx_sync_r, rx_prev_r;
  ph_state_t         rx_state_r, rx_state_s;
  logic [CW-1:0]     rx_cnt_r, rx_cnt_s;
  logic [2:0]        rx_bit_r, rx_bit_s;
  logic [7:0]        rx_shift_r, rx_shift_s;
  logic [7:0]        rx_data_r, rx_data_s;
  logic              rx_rdy_r, rx_rdy_s;
  logic              rx_ferr_r, rx_ferr_s;
  logic              rx_pulse_r, rx_pulse_s;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= rxd;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // RX next-state: start checked at half a bit, then every DIV cycles lands on a bit centre
  always_comb begin
    rx_state_s = rx_state_r;
    rx_cnt_s   = rx_cnt_r;
    rx_bit_s   = rx_bit_r;
    rx_shift_s = rx_shift_r;
    rx_data_s  = rx_data_r;
    rx_rdy_s   = 1'b0;
    rx_ferr_s  = 1'b0;
    rx_pulse_s = 1'b0;
    case (rx_state_r)
      ST_IDLE: begin
        if (rx_prev_r && !rx_sync_r) begin
          rx_cnt_s   = '0;
          rx_state_s = ST_START;
        end else begin
          rx_state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (rx_cnt_r == CW'(HALF - 1)) begin
          rx_pulse_s = 1'b1;
          rx_cnt_s   = '0;
          rx_bit_s   = 3'd0;
          if (!rx_sync_r) begin
            rx_state_s = ST_DATA;
          end else begin
            rx_state_s = ST_IDLE;
          end
        end else begin
          rx_cnt_s = rx_cnt_r + CW'(1);
        end
      end
      ST_DATA: begin
        if (rx_cnt_r == CW'(DIV - 1)) begin
          rx_pulse_s = 1'b1;
          rx_cnt_s   = '0;
          rx_shift_s = {rx_sync_r, rx_shift_r[7:1]};
          rx_bit_s   = rx_bit_r + 3'd1;
          if (rx_bit_r == 3'd7) begin
            rx_state_s = ST_STOP;
          end else begin
            rx_state_s = ST_DATA;
          end
        end else begin
          rx_cnt_s = rx_cnt_r + CW'(1);
        end
      end
      ST_STOP: begin
        if (rx_cnt_r == CW'(DIV - 1)) begin
          rx_pulse_s = 1'b1;
          rx_cnt_s   = '0;
          rx_state_s = ST_IDLE;
          if (rx_sync_r) begin
            rx_data_s = rx_shift_r;
            rx_rdy_s  = 1'b1;
          end else begin
            rx_ferr_s = 1'b1;
          end
        end else begin
          rx_cnt_s = rx_cnt_r + CW'(1);
        end
      end
      default: begin
        rx_state_s = ST_IDLE;
      end
    endcase
  end

  // RX state and registered strobes/data
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_state_r <= ST_IDLE;
      rx_cnt_r   <= '0;
      rx_bit_r   <= 3'd0;
      rx_shift_r <= 8'h00;
      rx_data_r  <= 8'h00;
      rx_rdy_r   <= 1'b0;
      rx_ferr_r  <= 1'b0;
      rx_pulse_r <= 1'b0;
    end else begin
      rx_state_r <= rx_state_s;
      rx_cnt_r   <= rx_cnt_s;
      rx_bit_r   <= rx_bit_s;
      rx_shift_r <= rx_shift_s;
      rx_data_r  <= rx_data_s;
      rx_rdy_r   <= rx_rdy_s;
      rx_ferr_r  <= rx_ferr_s;
      rx_pulse_r <= rx_pulse_s;
    end
  end

  assign txd             = txd_r;
  assign tx_busy         = tx_busy_r;
  assign rx_rdy          = rx_rdy_r;
  assign rx_data         = rx_data_r;
  assign rx_frame_err    = rx_ferr_r;
  assign rx_sample_pulse = rx_pulse_r;

endmodule
